// File: rtl/rf_shot_pkg.sv
// Shared types and defaults for the laser rangefinder shot sequencer.
// Optional feature macro (used by rf_shot_sequencer): RF_SHOT_SEQ_TEST_STOP_EN.
package rf_shot_pkg;

  localparam int CNT_W_DEFAULT           = 16;
  localparam int FIRE_CYCLES_DEFAULT     = 4;
  localparam int COMP_RST_CYCLES_DEFAULT = 8;

  // Shot phases in the order a normal shot walks through them.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHARGE = 3'd1,
    FIRE   = 3'd2,
    LISTEN = 3'd3,
    CRST   = 3'd4
  } state_t;

  // Level outputs that are a pure function of the state being entered.
  typedef struct packed {
    logic laser_charge;
    logic laser_fire;
    logic tdc_start;
    logic capture_en;
    logic comp_reset;
    logic busy;
  } drive_t;

  // Driver levels for a given state; the sequencer registers this alongside
  // the state so every level output comes straight from a flop.
  function automatic drive_t drive_for(input state_t s);
    drive_t d;
    // NOTE: start from a full default so no path through the case leaves a
    // field unassigned (which would infer a latch in combinational use).
    d      = '0;
    d.busy = (s != IDLE);
    unique case (s)
      CHARGE: d.laser_charge = 1'b1;
      FIRE: begin
        d.laser_fire = 1'b1;
        d.tdc_start  = 1'b1;
      end
      LISTEN: d.capture_en = 1'b1;
      CRST:   d.comp_reset = 1'b1;
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/rf_sync_edge.sv
// Two-flop synchronizer for the asynchronous comparator plus a rising-edge
// detector. While rearm is high the "previous level" flop is forced high, so
// a comparator that is already high (or rising) before the listen window
// opens cannot produce an edge; only a low-to-high transition that reaches
// the second synchronizer stage after rearm drops is reported.
module rf_sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  input  logic rearm,
  output logic rise
);

  logic sync_1;
  logic sync_2;
  logic prev;

  // Synchronizer chain and edge history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      prev   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make each flop sample the value its
      // predecessor held before this edge, which is what forms the chain.
      sync_1 <= din;
      sync_2 <= sync_1;
      prev   <= rearm ? 1'b1 : sync_2;
    end
  end

  // Rising edge of the synchronized comparator, one cycle wide.
  assign rise = sync_2 & ~prev;

endmodule

// File: rtl/rf_shot_sequencer.sv
// Laser rangefinder shot sequencer: charge, fire + TDC start, listen window
// with comparator hit timing, then comparator latch reset. One ordered,
// abortable sequence replaces independent per-output pulse generators.
// Optional feature macro: RF_SHOT_SEQ_TEST_STOP_EN adds test_mode/test_delay,
// which substitute an internal stop pulse for the comparator.
module rf_shot_sequencer
  import rf_shot_pkg::*;
#(
  parameter int CNT_W           = CNT_W_DEFAULT,
  parameter int FIRE_CYCLES     = FIRE_CYCLES_DEFAULT,
  parameter int COMP_RST_CYCLES = COMP_RST_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] charge_cycles,
  input  logic [CNT_W-1:0] window_cycles,
  input  logic             comparator,
`ifdef RF_SHOT_SEQ_TEST_STOP_EN
  input  logic             test_mode,
  input  logic [CNT_W-1:0] test_delay,
`endif
  output logic             laser_charge,
  output logic             laser_fire,
  output logic             tdc_start,
  output logic             capture_en,
  output logic             comp_reset,
  output logic             busy,
  output logic             done,
  output logic             hit,
  output logic [CNT_W-1:0] hit_time
);

  localparam int FW = (FIRE_CYCLES > 1) ? $clog2(FIRE_CYCLES) : 1;
  localparam int RW = (COMP_RST_CYCLES > 1) ? $clog2(COMP_RST_CYCLES) : 1;
  localparam logic [FW-1:0] FIRE_LAST = FW'(FIRE_CYCLES - 1);
  localparam logic [RW-1:0] CRST_LAST = RW'(COMP_RST_CYCLES - 1);

  state_t           state;
  drive_t           drv;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] charge_lat;
  logic [CNT_W-1:0] charge_last;
  logic [CNT_W-1:0] win_lat;
  logic [CNT_W-1:0] win_last;
  logic [FW-1:0]    fire_cnt;
  logic [RW-1:0]    crst_cnt;
  logic             abort_pend;
  logic             cmp_rise;
  logic             detect;
  logic             rearm;

  // Shared charge/listen counter saturates instead of wrapping.
  assign cnt_inc     = (cnt == '1) ? cnt : cnt + 1'b1;
  assign charge_last = charge_lat - 1'b1;
  // A zero-length window still listens for one cycle.
  assign win_last    = (win_lat == '0) ? '0 : win_lat - 1'b1;

  // The edge detector is held disarmed outside LISTEN so edges during FIRE
  // (or left over from the previous shot) never count as a return.
  assign rearm = (state != LISTEN);

  rf_sync_edge u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (comparator),
    .rearm   (rearm),
    .rise    (cmp_rise)
  );

`ifdef RF_SHOT_SEQ_TEST_STOP_EN
  // Test stop: an internal pulse at a programmed listen count replaces the
  // comparator. A delay beyond the window is never reached, so no hit.
  assign detect = test_mode ? (cnt == test_delay) : cmp_rise;
`else
  assign detect = cmp_rise;
`endif

  // Shot FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the latched shot configuration is reset too, so nothing about
      // a half-finished shot survives a reset.
      state      <= IDLE;
      drv        <= '0;
      cnt        <= '0;
      charge_lat <= '0;
      win_lat    <= '0;
      fire_cnt   <= '0;
      crst_cnt   <= '0;
      abort_pend <= 1'b0;
      done       <= 1'b0;
      hit        <= 1'b0;
      hit_time   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          // abort in the same cycle cancels the request outright
          if (start && !abort) begin
            charge_lat <= charge_cycles;
            win_lat    <= window_cycles;
            cnt        <= '0;
            fire_cnt   <= '0;
            abort_pend <= 1'b0;
            if (charge_cycles != '0) begin
              state <= CHARGE;
              drv   <= drive_for(CHARGE);
            end else begin
              state <= FIRE;
              drv   <= drive_for(FIRE);
            end
          end
        end

        CHARGE: begin
          if (abort) begin
            state <= IDLE;
            drv   <= drive_for(IDLE);
            done  <= 1'b1;
            hit   <= 1'b0;
          end else if (cnt == charge_last) begin
            state    <= FIRE;
            drv      <= drive_for(FIRE);
            fire_cnt <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end

        FIRE: begin
          // The laser pulse is never truncated; an abort is remembered and
          // acted on once the pulse has run its full length.
          if (abort) abort_pend <= 1'b1;
          if (fire_cnt == FIRE_LAST) begin
            if (abort || abort_pend) begin
              state    <= CRST;
              drv      <= drive_for(CRST);
              crst_cnt <= '0;
              hit      <= 1'b0;
            end else begin
              state <= LISTEN;
              drv   <= drive_for(LISTEN);
              cnt   <= '0;
            end
          end else begin
            fire_cnt <= fire_cnt + 1'b1;
          end
        end

        LISTEN: begin
          // Priority: abort, then a hit (even on the last cycle), then timeout.
          if (abort) begin
            state    <= CRST;
            drv      <= drive_for(CRST);
            crst_cnt <= '0;
            hit      <= 1'b0;
          end else if (detect) begin
            state    <= CRST;
            drv      <= drive_for(CRST);
            crst_cnt <= '0;
            hit      <= 1'b1;
            hit_time <= cnt;
          end else if (cnt >= win_last) begin
            state    <= CRST;
            drv      <= drive_for(CRST);
            crst_cnt <= '0;
            hit      <= 1'b0;
          end else begin
            cnt <= cnt_inc;
          end
        end

        CRST: begin
          if (crst_cnt == CRST_LAST) begin
            state <= IDLE;
            drv   <= drive_for(IDLE);
            done  <= 1'b1;
          end else begin
            crst_cnt <= crst_cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          drv   <= '0;
        end
      endcase
    end
  end

  assign laser_charge = drv.laser_charge;
  assign laser_fire   = drv.laser_fire;
  assign tdc_start    = drv.tdc_start;
  assign capture_en   = drv.capture_en;
  assign comp_reset   = drv.comp_reset;
  assign busy         = drv.busy;

endmodule
